mod_counter: RTL and testbench

- Parametrised modulo-N up/down counter. It generalises the team's fixed 0-to-13 counter.
- Modulus is a runtime input. Adds direction, enable, parallel load, prescaled stepping and a registered wrap pulse.
- Wrap is a synchronous next-state decision. The terminal value never drives the async reset path.
- Used as a timebase/sequence counter inside training designs and as a cascadable stage.

---
 rtl/mod_counter_pkg.sv | 11 +
 rtl/mod_counter_prescale_tick.sv | 31 +++
 rtl/mod_counter.sv | 75 +++++++
 tb/tb_mod_counter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and elaboration helpers for the modulo-N counter family.
package mod_counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  // Prescaler phase width; a single bit is kept even when no prescaling is needed.
  function automatic int prescale_w(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/mod_counter_prescale_tick.sv
// Enable-gated prescaler: pulses tick once every PRESCALE enabled cycles.
module prescale_tick
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = prescale_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // Phase only moves while enabled, so dropping en pauses without losing position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= '0;
    else if (clr)
      phase <= '0;
    else if (en)
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
  end

  assign tick = (PRESCALE == 1) ? 1'b1 : (phase == LAST);

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with runtime limit, parallel load, prescaled stepping
// and a registered wrap pulse. Define MOD_COUNTER_WRAP_CNT_EN to add a saturating wrap_cnt output.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  parameter int WRAP_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef MOD_COUNTER_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  logic tick;
  logic step;
  logic going_up;
  logic at_term;

  prescale_tick #(.PRESCALE(PRESCALE)) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign going_up = (dir_e'(dir) == DIR_UP);
  assign step     = en & tick;
  assign at_term  = going_up ? (count >= limit) : (count == '0);
  assign tc       = ~load & step & at_term;

  // Wrap is a next-state decision; >= on the way up recovers from a lowered limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= tc;
      if (load)
        count <= load_val;
      else if (step) begin
        if (going_up)
          count <= (count >= limit) ? '0 : count + 1'b1;
        else if (count == '0)
          count <= limit;
        else if (count > limit)
          count <= limit;
        else
          count <= count - 1'b1;
      end
    end
  end

`ifdef MOD_COUNTER_WRAP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wrap_cnt <= '0;
    else if (tc && (wrap_cnt != '1))
      wrap_cnt <= wrap_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed scenarios plus randomized traffic
// against a behavioural model, on a PRESCALE=1 and a PRESCALE=3 instance.
module tb_mod_counter;

  typedef struct {
    int cnt;
    bit wrp;
    int pre;
    int wcnt;
  } mstate_t;

  logic       clk;
  logic       rst;
  logic       en, dir, load;
  logic [3:0] load_val, limit;
  logic [3:0] count;
  logic       tc, wrap;
  logic       en3, dir3, load3;
  logic [3:0] lv3, lim3;
  logic [3:0] count3;
  logic       tc3, wrap3;
`ifdef MOD_COUNTER_WRAP_CNT_EN
  logic [1:0] wrap_cnt;
  logic [7:0] wrap_cnt3;
`endif

  int checks = 0;
  int errors = 0;
  mstate_t m, m3;

  mod_counter #(.WIDTH(4), .PRESCALE(1), .WRAP_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .limit(limit), .count(count), .tc(tc), .wrap(wrap)
`ifdef MOD_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  mod_counter #(.WIDTH(4), .PRESCALE(3), .WRAP_W(8)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .dir(dir3), .load(load3), .load_val(lv3),
    .limit(lim3), .count(count3), .tc(tc3), .wrap(wrap3)
`ifdef MOD_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one clock of the counter described in plain arithmetic.
  function automatic bit model_tick(mstate_t s, int presc);
    return (presc == 1) || (s.pre == presc - 1);
  endfunction

  function automatic bit model_tc(mstate_t s, int presc, bit e, bit d, bit ld, int lim);
    if (ld || !e || !model_tick(s, presc)) return 1'b0;
    return d ? (s.cnt >= lim) : (s.cnt == 0);
  endfunction

  function automatic mstate_t model_next(mstate_t s, int presc, bit r, bit e, bit d, bit ld,
                                         int lv, int lim, int wmax);
    mstate_t n;
    n = s;
    n.wrp = 1'b0;
    if (r) begin
      n.cnt = 0; n.pre = 0; n.wcnt = 0;
      return n;
    end
    if (ld) begin
      n.cnt = lv; n.pre = 0;
      return n;
    end
    if (e) n.pre = (s.pre >= presc - 1) ? 0 : s.pre + 1;
    if (e && model_tick(s, presc)) begin
      if (d) begin
        if (s.cnt >= lim) begin n.cnt = 0; n.wrp = 1'b1; end
        else n.cnt = s.cnt + 1;
      end else begin
        if (s.cnt == 0) begin n.cnt = lim; n.wrp = 1'b1; end
        else if (s.cnt > lim) n.cnt = lim;
        else n.cnt = s.cnt - 1;
      end
      if (n.wrp && n.wcnt < wmax) n.wcnt = n.wcnt + 1;
    end
    return n;
  endfunction

  task automatic step_clk();
    mstate_t n, n3;
    n  = model_next(m, 1, rst, en, dir, load, int'(load_val), int'(limit), 3);
    n3 = model_next(m3, 3, rst, en3, dir3, load3, int'(lv3), int'(lim3), 255);
    @(posedge clk);
    #1;
    m  = n;
    m3 = n3;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; dir = 1; load = 0; load_val = 0; limit = 0;
    en3 = 0; dir3 = 1; load3 = 0; lv3 = 0; lim3 = 0;
    m = '{0, 1'b0, 0, 0}; m3 = '{0, 1'b0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: count=%0d wrap=%0b expected 0/0", count, wrap);
    end
    checks++;
    if (count3 !== 4'd0 || wrap3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset3: count=%0d wrap=%0b expected 0/0", count3, wrap3);
    end
`ifdef MOD_COUNTER_WRAP_CNT_EN
    checks++;
    if (wrap_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset wrap_cnt: got %0d expected 0", wrap_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_up_count();
    limit = 4'd13; dir = 1; en = 1; load = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (count !== 4'(i % 14) || count !== 4'(m.cnt)) begin
        errors++;
        $display("[TB] FAIL up_count cyc %0d: count=%0d expected %0d", i, count, i % 14);
      end
      checks++;
      if (tc !== (i % 14 == 13) || wrap !== (i > 0 && i % 14 == 0)) begin
        errors++;
        $display("[TB] FAIL up_tc_wrap cyc %0d: tc=%0b wrap=%0b expected %0b/%0b",
                 i, tc, wrap, (i % 14 == 13), (i > 0 && i % 14 == 0));
      end
      step_clk();
    end
  endtask

  task automatic test_down_load();
    int exp_cnt[6] = '{2, 1, 0, 5, 4, 3};
    dir = 0; limit = 4'd5; load_val = 4'd2; load = 1; en = 0;
    step_clk();
    load = 0; en = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (count !== 4'(exp_cnt[i]) || count !== 4'(m.cnt)) begin
        errors++;
        $display("[TB] FAIL down_load cyc %0d: count=%0d expected %0d", i, count, exp_cnt[i]);
      end
      checks++;
      if (tc !== (exp_cnt[i] == 0) || wrap !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL down_tc_wrap cyc %0d: tc=%0b wrap=%0b expected %0b/%0b",
                 i, tc, wrap, (exp_cnt[i] == 0), (i == 3));
      end
      step_clk();
    end
  endtask

  task automatic test_limit_change();
    load = 1; load_val = 4'd9; limit = 4'd13; en = 0;
    step_clk();
    load = 0; en = 1; dir = 1; limit = 4'd6;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("[TB] FAIL limit_lowered_tc: tc=%0b expected 1", tc);
    end
    step_clk();
    checks++;
    if (count !== 4'd0 || wrap !== 1'b1 || count !== 4'(m.cnt)) begin
      errors++;
      $display("[TB] FAIL limit_lowered_up: count=%0d wrap=%0b expected 0/1", count, wrap);
    end
    load = 1; load_val = 4'd9; en = 0;
    step_clk();
    load = 0; en = 1; dir = 0;
    step_clk();
    checks++;
    if (count !== 4'd6 || wrap !== 1'b0 || count !== 4'(m.cnt)) begin
      errors++;
      $display("[TB] FAIL limit_lowered_down: count=%0d wrap=%0b expected 6/0", count, wrap);
    end
    en = 0;
  endtask

  task automatic test_load_priority();
    load = 1; load_val = 4'd13; limit = 4'd13; dir = 1; en = 0;
    step_clk();
    load = 1; load_val = 4'd7; en = 1;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_prio_tc: tc=%0b expected 0", tc);
    end
    step_clk();
    checks++;
    if (count !== 4'd7 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_prio: count=%0d wrap=%0b expected 7/0", count, wrap);
    end
    load = 0; en = 0;
  endtask

  task automatic test_async_reset();
    load = 1; load_val = 4'd7; limit = 4'd13; dir = 1; en = 0;
    step_clk();
    load = 0; en = 1;
    repeat (2) step_clk();
    checks++;
    if (count !== 4'd9) begin
      errors++;
      $display("[TB] FAIL pre_reset_count: count=%0d expected 9", count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: count=%0d wrap=%0b expected 0/0", count, wrap);
    end
    m = '{0, 1'b0, 0, 0}; m3 = '{0, 1'b0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step_clk();
    checks++;
    if (count !== 4'd1 || count !== 4'(m.cnt)) begin
      errors++;
      $display("[TB] FAIL resume_after_reset: count=%0d expected 1", count);
    end
    en = 0;
  endtask

  task automatic test_prescale();
    en = 0;
    load3 = 1; lv3 = 4'd0; lim3 = 4'd3; dir3 = 1; en3 = 0;
    step_clk();
    load3 = 0;
    for (int i = 0; i < 16; i++) begin
      en3 = (i == 4 || i == 5) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (count3 !== 4'(m3.cnt) || wrap3 !== m3.wrp || tc3 !== model_tc(m3, 3, en3, dir3, load3, int'(lim3))) begin
        errors++;
        $display("[TB] FAIL prescale cyc %0d: count=%0d wrap=%0b tc=%0b expected %0d/%0b/%0b", i,
                 count3, wrap3, tc3, m3.cnt, m3.wrp, model_tc(m3, 3, en3, dir3, load3, int'(lim3)));
      end
      step_clk();
    end
    // 14 enabled cycles give four steps: 0->1->2->3->0
    checks++;
    if (count3 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL prescale_total: count=%0d expected 0", count3);
    end
    en3 = 0;
  endtask

`ifdef MOD_COUNTER_WRAP_CNT_EN
  task automatic test_wrap_cnt();
    int exp_w[4] = '{1, 2, 3, 3};
    en = 0;
    #1 rst = 1'b1;
    m = '{0, 1'b0, 0, 0}; m3 = '{0, 1'b0, 0, 0};
    @(posedge clk);
    #1 rst = 1'b0;
    limit = 4'd0; dir = 1; en = 1; load = 0;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      checks++;
      if (wrap_cnt !== 2'(exp_w[i])) begin
        errors++;
        $display("[TB] FAIL wrap_cnt step %0d: got %0d expected %0d", i, wrap_cnt, exp_w[i]);
      end
    end
    load = 1; load_val = 4'd5;
    step_clk();
    load = 0; en = 0;
    checks++;
    if (wrap_cnt !== 2'd3) begin
      errors++;
      $display("[TB] FAIL wrap_cnt_load: got %0d expected 3", wrap_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (wrap_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL wrap_cnt_reset: got %0d expected 0", wrap_cnt);
    end
    m = '{0, 1'b0, 0, 0}; m3 = '{0, 1'b0, 0, 0};
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      dir = 1'($urandom);
      load = 1'($urandom_range(0, 7) == 0);
      load_val = 4'($urandom);
      if ($urandom_range(0, 9) == 0) limit = 4'($urandom);
      en3 = 1'($urandom_range(0, 3) != 0);
      dir3 = 1'($urandom);
      load3 = 1'($urandom_range(0, 9) == 0);
      lv3 = 4'($urandom);
      if ($urandom_range(0, 9) == 0) lim3 = 4'($urandom);
      #1;
      checks++;
      if (count !== 4'(m.cnt) || wrap !== m.wrp || tc !== model_tc(m, 1, en, dir, load, int'(limit))) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: count=%0d wrap=%0b tc=%0b expected %0d/%0b/%0b", i,
                 count, wrap, tc, m.cnt, m.wrp, model_tc(m, 1, en, dir, load, int'(limit)));
      end
      checks++;
      if (count3 !== 4'(m3.cnt) || wrap3 !== m3.wrp || tc3 !== model_tc(m3, 3, en3, dir3, load3, int'(lim3))) begin
        errors++;
        $display("[TB] FAIL random3 cyc %0d: count=%0d wrap=%0b tc=%0b expected %0d/%0b/%0b", i,
                 count3, wrap3, tc3, m3.cnt, m3.wrp, model_tc(m3, 3, en3, dir3, load3, int'(lim3)));
      end
`ifdef MOD_COUNTER_WRAP_CNT_EN
      checks++;
      if (wrap_cnt !== 2'(m.wcnt) || wrap_cnt3 !== 8'(m3.wcnt)) begin
        errors++;
        $display("[TB] FAIL random_wrap_cnt cyc %0d: got %0d/%0d expected %0d/%0d", i,
                 wrap_cnt, wrap_cnt3, m.wcnt, m3.wcnt);
      end
`endif
      step_clk();
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_load();
    test_limit_change();
    test_load_priority();
    test_async_reset();
    test_prescale();
`ifdef MOD_COUNTER_WRAP_CNT_EN
    test_wrap_cnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
